// File: rtl/periph_lock_pkg.sv
// Shared types and op-word decode for the peripheral lock arbiter.
// The tag-bearing localparams are templates; the top substitutes its own TAG.
package periph_lock_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    localparam logic [3:0]  TAG_DFLT  = 4'hA;
    localparam logic [7:0]  START_HI  = {4'hF, TAG_DFLT};
    localparam logic [15:0] STOP_WORD = {4'hF, TAG_DFLT, 8'hFF};

    typedef struct packed {
        logic       is_start;
        logic [3:0] prio;
        logic       is_stop;
        logic       is_zero;
    } op_dec_t;

    // is_start only checks the frame; a usable request also needs prio != 0
    function automatic op_dec_t decode(input logic [15:0] op,
                                       input logic [7:0]  start_hi,
                                       input logic [15:0] stop_word);
        op_dec_t d;
        d.is_start = (op[15:8] == start_hi) && (op[7:4] == 4'h0);
        d.prio     = op[3:0];
        d.is_stop  = (op == stop_word);
        d.is_zero  = (op == 16'h0000);
        return d;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational winner select: highest priority, ties broken by the first
// requester found searching upward from the round-robin pointer.
module rr_prio_pick #(
    parameter int NODES = 4
) (
    input  logic [NODES-1:0]   i_valid,
    input  logic [NODES*4-1:0] i_prio,
    input  logic [2:0]         i_rr_ptr,
    output logic [2:0]         o_winner,
    output logic               o_any_valid
);

    logic [3:0] w_best;
    int         w_idx;

    always_comb begin
        o_winner    = i_rr_ptr;
        o_any_valid = |i_valid;
        w_best      = 4'h0;
        w_idx       = 0;
        // strict > keeps the earliest tied node in search order
        for (int k = 0; k < NODES; k++) begin
            w_idx = int'(i_rr_ptr) + k;
            if (w_idx >= NODES) w_idx = w_idx - NODES;
            if (i_valid[w_idx] && (i_prio[w_idx*4 +: 4] > w_best)) begin
                w_best   = i_prio[w_idx*4 +: 4];
                o_winner = 3'(w_idx);
            end
        end
    end

endmodule

// File: rtl/periph_lock_arbiter.sv
// Exclusive lock over one 8-bit peripheral shared by NODES op-word buses,
// with priority/round-robin grant and an inactivity forced release.
module periph_lock_arbiter
    import periph_lock_pkg::*;
#(
    parameter int         NODES   = 4,
    parameter logic [3:0] TAG     = TAG_DFLT,
    parameter int         TIMEOUT = 1024
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NODES*16-1:0] in_op,
    output logic [7:0]          out_peripheral,
    output logic [NODES-1:0]    grant,
    output logic [2:0]          owner,
    output logic                busy,
    output logic                timeout_evt
);

    localparam logic [7:0]  L_START_HI = {START_HI[7:4], TAG};
    localparam logic [15:0] L_STOP     = {L_START_HI, STOP_WORD[7:0]};
    localparam int          CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] L_TC     = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t              r_state;
    logic [7:0]          r_out;
    logic [NODES-1:0]    r_grant;
    logic [2:0]          r_owner;
    logic                r_busy;
    logic                r_tevt;
    logic [CW-1:0]       r_idle_cnt;
    logic [2:0]          r_rr;

    op_dec_t             w_dec [NODES];
    logic [NODES-1:0]    w_valid;
    logic [NODES*4-1:0]  w_prio;
    logic [15:0]         w_own_op;
    op_dec_t             w_own;
    logic                w_own_start;
    logic                w_force;
    logic [2:0]          w_rr_next;
    logic [2:0]          w_win;
    logic                w_any;

    always_comb begin
        w_valid  = '0;
        w_prio   = '0;
        w_own_op = 16'h0000;
        for (int i = 0; i < NODES; i++) begin
            w_dec[i]        = decode(in_op[16*i +: 16], L_START_HI, L_STOP);
            w_valid[i]      = w_dec[i].is_start && (w_dec[i].prio != 4'h0);
            w_prio[4*i +: 4] = w_dec[i].prio;
            if (r_owner == 3'(i)) w_own_op = in_op[16*i +: 16];
        end
        w_own       = decode(w_own_op, L_START_HI, L_STOP);
        w_own_start = w_own.is_start && (w_own.prio != 4'h0);
        w_force     = (TIMEOUT != 0) && w_own.is_zero && (r_idle_cnt == L_TC);
        w_rr_next   = (r_owner == 3'(NODES - 1)) ? 3'd0 : r_owner + 3'd1;
    end

    rr_prio_pick #(
        .NODES (NODES)
    ) u_pick (
        .i_valid     (w_valid),
        .i_prio      (w_prio),
        .i_rr_ptr    (r_rr),
        .o_winner    (w_win),
        .o_any_valid (w_any)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_out      <= 8'h00;
            r_grant    <= '0;
            r_owner    <= 3'd0;
            r_busy     <= 1'b0;
            r_tevt     <= 1'b0;
            r_idle_cnt <= '0;
            r_rr       <= 3'd0;
        end else begin
            r_tevt <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_out <= 8'h00;
                    if (w_any) begin
                        r_grant    <= NODES'(1) << w_win;
                        r_owner    <= w_win;
                        r_busy     <= 1'b1;
                        r_idle_cnt <= '0;
                        r_state    <= HELD;
                    end
                end
                HELD: begin
                    if (w_own.is_stop || w_force) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_out   <= 8'h00;
                        r_rr    <= w_rr_next;
                        r_tevt  <= w_force;
                    end else if (w_own_start) begin
                        r_out      <= 8'h00;
                        r_idle_cnt <= '0;
                    end else if (w_own.is_zero) begin
                        if (r_idle_cnt != '1) r_idle_cnt <= r_idle_cnt + 1'b1;
                    end else begin
                        r_out      <= w_own_op[7:0];
                        r_idle_cnt <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_peripheral = r_out;
    assign grant          = r_grant;
    assign owner          = r_owner;
    assign busy           = r_busy;
    assign timeout_evt    = r_tevt;

endmodule

// File: tb/tb_periph_lock_arbiter.sv
// Directed bench for periph_lock_arbiter (NODES=4, TAG=A, TIMEOUT=8) with a
// queue scoreboard popped by an independent monitor one edge after each stimulus.
module tb_periph_lock_arbiter;

    logic        CLK;
    logic        RST;
    logic [63:0] in_op;
    logic [7:0]  out_peripheral;
    logic [3:0]  grant;
    logic [2:0]  owner;
    logic        busy;
    logic        timeout_evt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] g;
        logic [2:0] o;
        logic       b;
        logic [7:0] p;
        logic       t;
        string      nm;
    } exp_t;

    exp_t q[$];

    periph_lock_arbiter #(
        .NODES   (4),
        .TAG     (4'hA),
        .TIMEOUT (8)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .in_op          (in_op),
        .out_peripheral (out_peripheral),
        .grant          (grant),
        .owner          (owner),
        .busy           (busy),
        .timeout_evt    (timeout_evt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cmp(input string nm, input logic [3:0] g, input logic [2:0] o,
                       input logic b, input logic [7:0] p, input logic t);
        checks++;
        if ({grant, owner, busy, out_peripheral, timeout_evt} !== {g, o, b, p, t}) begin
            errors++;
            $display("FAIL %s: got grant=%b owner=%0d busy=%b out=%h tevt=%b, want grant=%b owner=%0d busy=%b out=%h tevt=%b",
                     nm, grant, owner, busy, out_peripheral, timeout_evt, g, o, b, p, t);
        end
    endtask

    task automatic step(input logic [15:0] o0, input logic [15:0] o1,
                        input logic [15:0] o2, input logic [15:0] o3,
                        input logic [3:0] g, input logic [2:0] ow, input logic b,
                        input logic [7:0] p, input logic t, input string nm);
        exp_t e;
        @(negedge CLK);
        in_op = {o3, o2, o1, o0};
        e.g = g; e.o = ow; e.b = b; e.p = p; e.t = t; e.nm = nm;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.nm, e.g, e.o, e.b, e.p, e.t);
            end
        end
    end

    initial begin : stim
        int waited;
        RST   = 1'b1;
        in_op = '0;
        repeat (3) @(posedge CLK);
        #1;
        cmp("reset_state", 4'b0000, 3'd0, 1'b0, 8'h00, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        // single requester: grant, data, stop
        step(16'h0, 16'h0, 16'hFA05, 16'h0, 4'b0100, 3'd2, 1'b1, 8'h00, 1'b0, "t1_grant");
        step(16'h0, 16'h0, 16'h1237, 16'h0, 4'b0100, 3'd2, 1'b1, 8'h37, 1'b0, "t1_data");
        step(16'h0, 16'h0, 16'hFAFF, 16'h0, 4'b0000, 3'd2, 1'b0, 8'h00, 1'b0, "t1_stop");

        // priority wins; foreign stop ignored
        step(16'hFA03, 16'h0, 16'h0, 16'hFA09, 4'b1000, 3'd3, 1'b1, 8'h00, 1'b0, "t2_prio");
        step(16'hFAFF, 16'h0, 16'h0, 16'h0042, 4'b1000, 3'd3, 1'b1, 8'h42, 1'b0, "t2_foreign_stop");
        step(16'h0, 16'h0, 16'h0, 16'hFAFF, 4'b0000, 3'd3, 1'b0, 8'h00, 1'b0, "t2_stop");

        // equal priority round robin 0,1,2,3,0 with a forced idle cycle after each release
        step(16'hFA07, 16'hFA07, 16'hFA07, 16'hFA07, 4'b0001, 3'd0, 1'b1, 8'h00, 1'b0, "t3_rr0");
        step(16'hFAFF, 16'hFA07, 16'hFA07, 16'hFA07, 4'b0000, 3'd0, 1'b0, 8'h00, 1'b0, "t3_rel0");
        step(16'hFA07, 16'hFA07, 16'hFA07, 16'hFA07, 4'b0010, 3'd1, 1'b1, 8'h00, 1'b0, "t3_rr1");
        step(16'hFA07, 16'hFAFF, 16'hFA07, 16'hFA07, 4'b0000, 3'd1, 1'b0, 8'h00, 1'b0, "t3_rel1");
        step(16'hFA07, 16'hFA07, 16'hFA07, 16'hFA07, 4'b0100, 3'd2, 1'b1, 8'h00, 1'b0, "t3_rr2");
        step(16'hFA07, 16'hFA07, 16'hFAFF, 16'hFA07, 4'b0000, 3'd2, 1'b0, 8'h00, 1'b0, "t3_rel2");
        step(16'hFA07, 16'hFA07, 16'hFA07, 16'hFA07, 4'b1000, 3'd3, 1'b1, 8'h00, 1'b0, "t3_rr3");
        step(16'hFA07, 16'hFA07, 16'hFA07, 16'hFAFF, 4'b0000, 3'd3, 1'b0, 8'h00, 1'b0, "t3_rel3");
        step(16'hFA07, 16'hFA07, 16'hFA07, 16'hFA07, 4'b0001, 3'd0, 1'b1, 8'h00, 1'b0, "t3_rr0_wrap");
        step(16'hFAFF, 16'h0, 16'h0, 16'h0, 4'b0000, 3'd0, 1'b0, 8'h00, 1'b0, "t3_rel_wrap");

        // inactivity: 7 zeros hold, data restarts the count, 8th zero forces release
        step(16'h0, 16'hFA05, 16'h0, 16'h0, 4'b0010, 3'd1, 1'b1, 8'h00, 1'b0, "t4_grant");
        step(16'h0, 16'h0055, 16'h0, 16'h0, 4'b0010, 3'd1, 1'b1, 8'h55, 1'b0, "t4_data");
        for (int i = 0; i < 7; i++)
            step(16'h0, 16'h0, 16'h0, 16'h0, 4'b0010, 3'd1, 1'b1, 8'h55, 1'b0, "t4_zero_a");
        step(16'h0, 16'h0055, 16'h0, 16'h0, 4'b0010, 3'd1, 1'b1, 8'h55, 1'b0, "t4_data_rst");
        for (int i = 0; i < 7; i++)
            step(16'h0, 16'h0, 16'h0, 16'h0, 4'b0010, 3'd1, 1'b1, 8'h55, 1'b0, "t4_zero_b");
        step(16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 3'd1, 1'b0, 8'h00, 1'b1, "t4_timeout");
        step(16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 3'd1, 1'b0, 8'h00, 1'b0, "t4_pulse_end");
        step(16'h0, 16'hFA05, 16'h0, 16'h0, 4'b0010, 3'd1, 1'b1, 8'h00, 1'b0, "t4_regrant");
        step(16'h0, 16'hFAFF, 16'h0, 16'h0, 4'b0000, 3'd1, 1'b0, 8'h00, 1'b0, "t4_stop");

        // prio 0 and wrong tag never granted
        for (int i = 0; i < 3; i++)
            step(16'h0, 16'hFA00, 16'hFB05, 16'h0, 4'b0000, 3'd1, 1'b0, 8'h00, 1'b0, "t5_ignored");

        // async reset while held
        step(16'h0, 16'h0, 16'h0, 16'hFA01, 4'b1000, 3'd3, 1'b1, 8'h00, 1'b0, "t6_grant");
        step(16'h0, 16'h0, 16'h0, 16'h00AB, 4'b1000, 3'd3, 1'b1, 8'hAB, 1'b0, "t6_data");
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        cmp("t6_async_rst", 4'b0000, 3'd0, 1'b0, 8'h00, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        step(16'h0, 16'h0, 16'h0, 16'h00AB, 4'b0000, 3'd0, 1'b0, 8'h00, 1'b0, "t6_no_relock");
        step(16'h0, 16'h0, 16'h0, 16'hFA01, 4'b1000, 3'd3, 1'b1, 8'h00, 1'b0, "t6_regrant");

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge CLK);
            waited++;
        end
        #2;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/periph_lock_arbiter.md
Name: periph_lock_arbiter

Overview:
- Shares one 8-bit peripheral output among NODES requesting nodes, each driving a 16-bit op word.
- Decodes tagged start/stop words and grants an exclusive lock by request priority, with round-robin tie-break.
- Forwards the owner's data byte to the peripheral and forces release after an inactivity timeout.
- Sits between the node op buses and any single-owner peripheral, e.g. the LED bank.

Parameters:
- NODES, 4, number of requesters (2..8)
- TAG, 4'hA, function tag carried in op[11:8]
- TIMEOUT, 1024, consecutive all-zero owner words before forced release; 0 disables the timeout

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- in_op  in  NODES*16  op words; node i drives in_op[16*i+15:16*i]
- out_peripheral  out  8  registered data to the peripheral
- grant  out  NODES  one-hot lock owner; all zero when free
- owner  out  3  index of the current or last owner
- busy  out  1  lock held
- timeout_evt  out  1  one-cycle pulse on forced release

Behaviour:
- Word decode, per node:
  - start = op[15:12]==4'hF, op[11:8]==TAG, op[7:4]==0, prio=op[3:0]!=0
  - stop = op == {4'hF, TAG, 8'hFF}
  - zero = op == 0
  - data = any other word
- Reset (async, on RST high): state IDLE; out_peripheral=0, grant=0, owner=0, busy=0, timeout_evt=0, idle_cnt=0, rr_ptr=0.
- IDLE state:
  - out_peripheral=0.
  - If any node presents a valid start, select the highest prio. Ties go to the first tied node searching upward from rr_ptr, with wrap-around.
  - Winner latched at the next edge: grant[w]=1, owner=w, busy=1, state HELD, idle_cnt=0. Request-to-grant latency is one edge.
  - Start words with prio 0 or a wrong tag are ignored.
- HELD state (only owner's word examined; other nodes' words ignored, including their stop words):
  - stop: next edge goes to IDLE. grant=0, busy=0, out_peripheral=0, rr_ptr=owner+1 mod NODES.
  - start (re-request): out_peripheral=0, idle_cnt=0, remain HELD.
  - data: out_peripheral=op[7:0], idle_cnt=0.
  - zero: out_peripheral holds its value; idle_cnt increments.
  - Forced release: when idle_cnt==TIMEOUT-1 and the word is zero (TIMEOUT!=0), the next edge releases exactly as for stop and timeout_evt=1 for one cycle.
- At least one IDLE cycle always separates two grants. Requests present on the release edge are arbitrated in the following IDLE cycle.
- idle_cnt width is clog2(TIMEOUT+1). It saturates and never wraps.
- grant is always one-hot or zero. busy == |grant.
- Reset asserted mid-HELD: immediate release, all outputs to reset values, no timeout_evt.

Decomposition:
- Package periph_lock_pkg:
  - state enum {IDLE, HELD}
  - START_HI and STOP_WORD localparams built from TAG
  - decode function returning {is_start, prio, is_stop, is_zero}
- Sub-module rr_prio_pick: combinational pick of max prio with round-robin from rr_ptr. Inputs are the per-node valid/prio vectors and rr_ptr; outputs are winner index and any_valid.
- Top holds the FSM, idle counter, output registers and rr_ptr.

Test Plan (NODES=4, TAG=A, TIMEOUT=8):
1. Node2 drives 0xFA05 -> grant=4'b0100, owner=2, busy=1 after one edge. Node2 drives 0x1237 -> out_peripheral=0x37. Node2 drives 0xFAFF -> grant=0, out_peripheral=0 next edge.
2. Node0 0xFA03 and node3 0xFA09 in the same cycle -> owner=3. Node0 drives 0xFAFF during the hold -> ignored, grant stays 4'b1000.
3. All nodes drive 0xFA07 from reset -> owner=0. After release and re-request -> owner=1, then 2, then 3, then 0.
4. Owner1 sends 0x0055 then eight 0x0000 words -> out_peripheral stays 0x55. After the 8th zero: timeout_evt pulses once, grant=0, busy=0. A 9th request is then granted normally.
5. Node1 drives 0xFA00, node2 drives 0xFB05 -> grant stays 0 indefinitely.
6. Assert RST while node3 holds the lock with out_peripheral=0xAB -> all outputs 0 immediately, no timeout_evt. After RST deassertion, node3 needs a new start to regain the lock.
